// File: rtl/psg_bus_pkg.sv
//==============================================================================
// psg_bus_pkg : shared types and constants for the PSG bus master
// Rev 1.0
//==============================================================================
`default_nettype none

package psg_bus_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        A_SETUP = 4'd1,
        A_STRB  = 4'd2,
        A_HOLD  = 4'd3,
        GAP     = 4'd4,
        D_SETUP = 4'd5,
        D_STRB  = 4'd6,
        D_HOLD  = 4'd7
    } psg_state_e;

    localparam int c_SETUP_CYC_DEF  = 1;
    localparam int c_STROBE_CYC_DEF = 2;
    localparam int c_HOLD_CYC_DEF   = 1;

    // AY-3-8910 style register map
    localparam logic [3:0] c_REG_A_FINE     = 4'd0;
    localparam logic [3:0] c_REG_A_COARSE   = 4'd1;
    localparam logic [3:0] c_REG_B_FINE     = 4'd2;
    localparam logic [3:0] c_REG_B_COARSE   = 4'd3;
    localparam logic [3:0] c_REG_C_FINE     = 4'd4;
    localparam logic [3:0] c_REG_C_COARSE   = 4'd5;
    localparam logic [3:0] c_REG_NOISE      = 4'd6;
    localparam logic [3:0] c_REG_MIXER      = 4'd7;
    localparam logic [3:0] c_REG_A_AMP      = 4'd8;
    localparam logic [3:0] c_REG_B_AMP      = 4'd9;
    localparam logic [3:0] c_REG_C_AMP      = 4'd10;
    localparam logic [3:0] c_REG_ENV_FINE   = 4'd11;
    localparam logic [3:0] c_REG_ENV_COARSE = 4'd12;
    localparam logic [3:0] c_REG_ENV_SHAPE  = 4'd13;
    localparam logic [3:0] c_REG_IO_A       = 4'd14;
    localparam logic [3:0] c_REG_IO_B       = 4'd15;

endpackage

`default_nettype wire

// File: rtl/psg_phase_timer.sv
//==============================================================================
// psg_phase_timer : 4-bit load / count-down / zero-flag phase counter
// Rev 1.0
//==============================================================================
`default_nettype none

module psg_phase_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [3:0] i_value,
    output logic       o_zero
);

    logic [3:0] r_cnt;

    // Saturates at zero so a phase never wraps into a long count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_zero = (r_cnt == 4'd0);

endmodule

`default_nettype wire

// File: rtl/psg_bus_master.sv
//==============================================================================
// psg_bus_master : request-driven PSG register bus master with address cache
// Rev 1.0
//==============================================================================
`default_nettype none

module psg_bus_master
    import psg_bus_pkg::*;
#(
    parameter int SETUP_CYC  = c_SETUP_CYC_DEF,
    parameter int STROBE_CYC = c_STROBE_CYC_DEF,
    parameter int HOLD_CYC   = c_HOLD_CYC_DEF,
    parameter bit ADDR_CACHE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rd,
    input  logic [3:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic       flush_addr,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       psg_asel,
    output logic       psg_cs_n,
    output logic       psg_wr_n,
    output logic       psg_rd_n,
    output logic [7:0] psg_do,
    input  logic [7:0] psg_di
);

    localparam logic [3:0] c_SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] c_STRB_LD  = 4'(STROBE_CYC - 1);
    localparam logic [3:0] c_HOLD_LD  = 4'(HOLD_CYC - 1);

    psg_state_e r_state;
    psg_state_e w_state_nxt;

    logic       r_ready;
    logic       r_busy;
    logic       r_rd;
    logic [3:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_cache_vld;
    logic [3:0] r_cache_addr;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_rdata;
    logic       r_asel;
    logic       r_cs_n;
    logic       r_wr_n;
    logic       r_rd_n;
    logic [7:0] r_do;

    logic       w_accept;
    logic       w_hit;
    logic       w_zero;
    logic       w_load;
    logic [3:0] w_load_val;
    logic       w_a_hold_end;
    logic       w_rd_eff;
    logic [3:0] w_addr_eff;
    logic [7:0] w_wdata_eff;
    logic       w_asel_nxt;
    logic       w_cs_n_nxt;
    logic       w_wr_n_nxt;
    logic       w_rd_n_nxt;
    logic [7:0] w_do_nxt;

    assign w_accept     = req_valid && r_ready;
    assign w_hit        = ADDR_CACHE && r_cache_vld && (req_addr == r_cache_addr) && !flush_addr;
    assign w_a_hold_end = (r_state == A_HOLD) && w_zero;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = w_hit ? D_SETUP : A_SETUP;
            A_SETUP: if (w_zero)   w_state_nxt = A_STRB;
            A_STRB:  if (w_zero)   w_state_nxt = A_HOLD;
            A_HOLD:  if (w_zero)   w_state_nxt = GAP;
            GAP:                   w_state_nxt = D_SETUP;
            D_SETUP: if (w_zero)   w_state_nxt = D_STRB;
            D_STRB:  if (w_zero)   w_state_nxt = D_HOLD;
            D_HOLD:  if (w_zero)   w_state_nxt = IDLE;
            default:               w_state_nxt = IDLE;
        endcase
    end

    // Every state change reloads the timer with the new phase length minus one.
    assign w_load = (w_state_nxt != r_state);

    always_comb begin
        w_load_val = 4'd0;
        case (w_state_nxt)
            A_SETUP, D_SETUP: w_load_val = c_SETUP_LD;
            A_STRB,  D_STRB:  w_load_val = c_STRB_LD;
            A_HOLD,  D_HOLD:  w_load_val = c_HOLD_LD;
            default:          w_load_val = 4'd0;
        endcase
    end

    psg_phase_timer u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_zero  (w_zero)
    );

    // Bus outputs are registered from the next state, so on the accept edge
    // the request fields must be taken straight from the inputs.
    assign w_rd_eff    = w_accept ? req_rd    : r_rd;
    assign w_addr_eff  = w_accept ? req_addr  : r_addr;
    assign w_wdata_eff = w_accept ? req_wdata : r_wdata;

    always_comb begin
        w_asel_nxt = 1'b0;
        w_cs_n_nxt = 1'b1;
        w_wr_n_nxt = 1'b1;
        w_rd_n_nxt = 1'b1;
        w_do_nxt   = 8'h00;
        case (w_state_nxt)
            A_SETUP, A_STRB, A_HOLD: begin
                w_asel_nxt = 1'b1;
                w_cs_n_nxt = 1'b0;
                w_do_nxt   = {4'h0, w_addr_eff};
                w_wr_n_nxt = (w_state_nxt != A_STRB);
            end
            D_SETUP, D_STRB, D_HOLD: begin
                w_cs_n_nxt = 1'b0;
                w_do_nxt   = w_rd_eff ? 8'h00 : w_wdata_eff;
                if (w_state_nxt == D_STRB) begin
                    w_wr_n_nxt = w_rd_eff;
                    w_rd_n_nxt = !w_rd_eff;
                end
            end
            default: begin
                w_cs_n_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_rd         <= 1'b0;
            r_addr       <= 4'd0;
            r_wdata      <= 8'h00;
            r_cache_vld  <= 1'b0;
            r_cache_addr <= 4'd0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= 8'h00;
            r_asel       <= 1'b0;
            r_cs_n       <= 1'b1;
            r_wr_n       <= 1'b1;
            r_rd_n       <= 1'b1;
            r_do         <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == IDLE);
            r_busy  <= (w_state_nxt != IDLE);
            if (w_accept) begin
                r_rd    <= req_rd;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            // A flush on the same edge as the cache load leaves the cache invalid.
            if (flush_addr) begin
                r_cache_vld <= 1'b0;
            end else if (w_a_hold_end) begin
                r_cache_vld <= 1'b1;
            end
            if (w_a_hold_end) begin
                r_cache_addr <= r_addr;
            end
            if ((r_state == D_STRB) && w_zero && r_rd) begin
                r_rsp_rdata <= psg_di;
            end
            r_rsp_valid <= (r_state == D_HOLD) && w_zero && r_rd;
            r_asel      <= w_asel_nxt;
            r_cs_n      <= w_cs_n_nxt;
            r_wr_n      <= w_wr_n_nxt;
            r_rd_n      <= w_rd_n_nxt;
            r_do        <= w_do_nxt;
        end
    end

    assign req_ready = r_ready;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign psg_asel  = r_asel;
    assign psg_cs_n  = r_cs_n;
    assign psg_wr_n  = r_wr_n;
    assign psg_rd_n  = r_rd_n;
    assign psg_do    = r_do;

endmodule

`default_nettype wire

// File: tb/tb_psg_bus_master.sv
//==============================================================================
// tb_psg_bus_master : directed self-checking bench for psg_bus_master
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_psg_bus_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid_a, req_valid_b, req_rd, flush_addr;
    logic [3:0] req_addr;
    logic [7:0] req_wdata, psg_di;

    logic       ready_a, rv_a, busy_a, asel_a, cs_a, wr_a, rd_a;
    logic [7:0] rdata_a, do_a;
    logic       ready_b, rv_b, busy_b, asel_b, cs_b, wr_b, rd_b;
    logic [7:0] rdata_b, do_b;

    int total = 0;
    int bad   = 0;
    int viol;

    logic [39:0] v_cs, v_wr, v_rd, v_asel, v_rdy, v_rv, v_busy;
    logic [7:0]  s_do    [0:39];
    logic [7:0]  s_rdata [0:39];

    logic        t_rd, t_hit, b_vld;
    logic [3:0]  t_addr, b_addr;
    logic [7:0]  t_wd, t_di;
    logic [5:0]  t_last;

    always #5 clk = ~clk;

    psg_bus_master dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_ready(ready_a),
        .req_rd(req_rd), .req_addr(req_addr), .req_wdata(req_wdata),
        .flush_addr(flush_addr), .rsp_valid(rv_a), .rsp_rdata(rdata_a), .busy(busy_a),
        .psg_asel(asel_a), .psg_cs_n(cs_a), .psg_wr_n(wr_a), .psg_rd_n(rd_a),
        .psg_do(do_a), .psg_di(psg_di)
    );

    psg_bus_master #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2), .ADDR_CACHE(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(ready_b),
        .req_rd(req_rd), .req_addr(req_addr), .req_wdata(req_wdata),
        .flush_addr(flush_addr), .rsp_valid(rv_b), .rsp_rdata(rdata_b), .busy(busy_b),
        .psg_asel(asel_b), .psg_cs_n(cs_b), .psg_wr_n(wr_b), .psg_rd_n(rd_b),
        .psg_do(do_b), .psg_di(psg_di)
    );

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; the request is accepted on the next rising edge.
    task automatic issue(input logic sel, input logic rd, input logic [3:0] addr, input logic [7:0] wd);
        req_rd    = rd;
        req_addr  = addr;
        req_wdata = wd;
        if (sel) req_valid_b = 1'b1;
        else     req_valid_a = 1'b1;
        check("ready_at_issue", 40'(sel ? ready_b : ready_a), 40'd1);
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
    endtask

    // Records cycles 1..n after the accept edge; bit k-1 holds cycle k.
    task automatic trace(input logic sel, input int n, input int flush_k, input logic [7:0] di_val);
        logic       cs, wr, rd;
        logic [5:0] ix;
        v_cs = '0; v_wr = '0; v_rd = '0; v_asel = '0; v_rdy = '0; v_rv = '0; v_busy = '0;
        viol = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            ix = 6'(k - 1);
            cs = sel ? cs_b : cs_a;
            wr = sel ? wr_b : wr_a;
            rd = sel ? rd_b : rd_a;
            v_cs[ix]    = cs;
            v_wr[ix]    = wr;
            v_rd[ix]    = rd;
            v_asel[ix]  = sel ? asel_b  : asel_a;
            v_rdy[ix]   = sel ? ready_b : ready_a;
            v_rv[ix]    = sel ? rv_b    : rv_a;
            v_busy[ix]  = sel ? busy_b  : busy_a;
            s_do[ix]    = sel ? do_b    : do_a;
            s_rdata[ix] = sel ? rdata_b : rdata_a;
            if ((!wr && !rd) || ((!wr || !rd) && cs)) viol++;
            psg_di     = !rd ? di_val : 8'h00;
            flush_addr = (k == flush_k);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid_a = 1'b0; req_valid_b = 1'b0; req_rd = 1'b0;
        req_addr = 4'd0; req_wdata = 8'h00; flush_addr = 1'b0; psg_di = 8'h00;
        repeat (3) @(negedge clk);

        check("rst_cs_n",  40'(cs_a),    40'd1);
        check("rst_wr_n",  40'(wr_a),    40'd1);
        check("rst_rd_n",  40'(rd_a),    40'd1);
        check("rst_asel",  40'(asel_a),  40'd0);
        check("rst_do",    40'(do_a),    40'd0);
        check("rst_rv",    40'(rv_a),    40'd0);
        check("rst_rdata", 40'(rdata_a), 40'd0);
        check("rst_busy",  40'(busy_a),  40'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 40'(ready_a), 40'd1);

        // Cold write addr 7 / 0x38 with default timing
        issue(1'b0, 1'b0, 4'd7, 8'h38);
        trace(1'b0, 10, 0, 8'h00);
        check("w1_cs",   v_cs,   40'h210);
        check("w1_wr",   v_wr,   40'h339);
        check("w1_rd",   v_rd,   40'h3FF);
        check("w1_asel", v_asel & 40'h1EF, 40'h00F);
        check("w1_rdy",  v_rdy,  40'h200);
        check("w1_busy", v_busy, 40'h1FF);
        check("w1_rv",   v_rv,   40'h000);
        check("w1_do_a2", 40'(s_do[1]), 40'h07);
        check("w1_do_a3", 40'(s_do[2]), 40'h07);
        check("w1_do_d7", 40'(s_do[6]), 40'h38);
        check("w1_do_d8", 40'(s_do[7]), 40'h38);

        // Same address again: cached, data phase only
        issue(1'b0, 1'b0, 4'd7, 8'h3F);
        trace(1'b0, 5, 0, 8'h00);
        check("w2_cs",   v_cs,   40'h10);
        check("w2_wr",   v_wr,   40'h19);
        check("w2_asel", v_asel, 40'h00);
        check("w2_rdy",  v_rdy,  40'h10);
        check("w2_do",   40'(s_do[1]), 40'h3F);

        // Read addr 14 (address miss), then again (hit)
        issue(1'b0, 1'b1, 4'd14, 8'h00);
        trace(1'b0, 11, 0, 8'hA5);
        check("r1_rd",    v_rd, 40'h73F);
        check("r1_wr",    v_wr, 40'h7F9);
        check("r1_rv",    v_rv, 40'h200);
        check("r1_rdata", 40'(s_rdata[9]),  40'hA5);
        check("r1_hold",  40'(s_rdata[10]), 40'hA5);
        check("r1_do_a",  40'(s_do[1]), 40'h0E);
        check("r1_do_d",  40'(s_do[6]), 40'h00);

        issue(1'b0, 1'b1, 4'd14, 8'h00);
        trace(1'b0, 6, 0, 8'h5A);
        check("r2_wr",    v_wr, 40'h3F);
        check("r2_rd",    v_rd, 40'h39);
        check("r2_rv",    v_rv, 40'h10);
        check("r2_rdata", 40'(s_rdata[4]), 40'h5A);

        // Flush while idle forces a fresh address phase
        issue(1'b0, 1'b0, 4'd7, 8'h11);
        trace(1'b0, 10, 0, 8'h00);
        check("f0_rdy", v_rdy, 40'h200);
        flush_addr = 1'b1;
        @(negedge clk);
        flush_addr = 1'b0;
        issue(1'b0, 1'b0, 4'd7, 8'h12);
        trace(1'b0, 10, 0, 8'h00);
        check("f1_asel", v_asel & 40'h1EF, 40'h00F);
        check("f1_rdy",  v_rdy, 40'h200);

        // Flush on the edge that ends A_HOLD wins over the cache load
        issue(1'b0, 1'b0, 4'd9, 8'h21);
        trace(1'b0, 10, 4, 8'h00);
        check("f2_rdy", v_rdy, 40'h200);
        issue(1'b0, 1'b0, 4'd9, 8'h22);
        trace(1'b0, 10, 0, 8'h00);
        check("f3_asel", v_asel & 40'h1EF, 40'h00F);
        check("f3_rdy",  v_rdy, 40'h200);

        // Asynchronous reset in the middle of D_STRB
        issue(1'b0, 1'b0, 4'd5, 8'h33);
        trace(1'b0, 7, 0, 8'h00);
        check("ar_pre_wr", 40'(wr_a), 40'd0);
        #1 rst_n = 1'b0;
        #1;
        check("ar_cs", 40'(cs_a), 40'd1);
        check("ar_wr", 40'(wr_a), 40'd1);
        check("ar_rd", 40'(rd_a), 40'd1);
        check("ar_rv", 40'(rv_a), 40'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ar_ready", 40'(ready_a), 40'd1);
        check("ar_rv2",   40'(rv_a),    40'd0);
        issue(1'b0, 1'b0, 4'd5, 8'h34);
        trace(1'b0, 10, 0, 8'h00);
        check("ar_asel", v_asel & 40'h1EF, 40'h00F);
        check("ar_rdy",  v_rdy, 40'h200);

        // Back-to-back random traffic on the 3/4/2 instance
        b_vld  = 1'b0;
        b_addr = 4'd0;
        for (int t = 0; t < 12; t++) begin
            t_rd   = 1'($urandom_range(0, 1));
            t_addr = 4'($urandom_range(0, 2));
            t_wd   = 8'($urandom_range(0, 255));
            t_di   = 8'($urandom_range(1, 255));
            t_hit  = b_vld && (t_addr == b_addr);
            issue(1'b1, t_rd, t_addr, t_wd);
            trace(1'b1, t_hit ? 10 : 20, 0, t_di);
            t_last = t_hit ? 6'd9 : 6'd19;
            check("b_viol", 40'(viol), 40'd0);
            if (t_hit) begin
                check("b_cs",  v_cs,  40'h200);
                check("b_rdy", v_rdy, 40'h200);
                check("b_wr",  v_wr,  t_rd ? 40'h3FF : 40'h387);
                check("b_rd",  v_rd,  t_rd ? 40'h387 : 40'h3FF);
            end else begin
                check("b_cs",  v_cs,  40'h80200);
                check("b_rdy", v_rdy, 40'h80000);
                check("b_wr",  v_wr,  t_rd ? 40'hFFF87 : 40'hE1F87);
                check("b_rd",  v_rd,  t_rd ? 40'hE1FFF : 40'hFFFFF);
            end
            check("b_rv", v_rv, t_rd ? v_rdy : 40'h0);
            if (t_rd) check("b_rdata", 40'(s_rdata[t_last]), 40'(t_di));
            if (!t_hit) begin
                b_vld  = 1'b1;
                b_addr = t_addr;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
